// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: valid/ready command sequencer for a 4-bit universal
// shift register (hold/shr/shl/load on s1,s0, clocked on falling edge).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; ready only in IDLE
//   cmd_op/cnt/data/fill  opcode, step count, load value, serial fill
//   sr_s1/s0            register mode select
//   sr_datain           register parallel input (latched data)
//   sr_msbin/lsbin      register serial inputs (fill or rotate feedback)
//   sr_rst              register synchronous clear
//   sr_q                register parallel output
//   busy/done/err       in progress, completion pulse, illegal-op flag
//   result              register value captured at completion

module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  output logic             sr_s1,
  output logic             sr_s0,
  output logic [WIDTH-1:0] sr_datain,
  output logic             sr_msbin,
  output logic             sr_lsbin,
  output logic             sr_rst,
  input  logic [WIDTH-1:0] sr_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LD  = 3'd1;
  localparam logic [2:0] OP_SHR = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;
  localparam logic [2:0] OP_ROL = 3'd5;
  localparam logic [2:0] OP_CLR = 3'd6;
  localparam logic [2:0] OP_BAD = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             fill_q;
  logic [WIDTH-1:0] res_q;

  logic accept;
  logic one_shot;
  logic acc_run;

  assign accept = (state == IDLE) && cmd_valid;

  // LOAD and CLEAR take one RUN cycle; the counter is
  // preloaded with 1 for them so the exit test is shared.
  assign one_shot = (cmd_op == OP_LD) || (cmd_op == OP_CLR);

  always_comb begin
    acc_run = 1'b0;
    case (cmd_op)
      OP_LD, OP_CLR: acc_run = 1'b1;
      OP_SHR, OP_SHL,
      OP_ROR, OP_ROL: acc_run = (cmd_cnt != '0);
      default:        acc_run = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_NOP;
      cnt_q  <= '0;
      data_q <= '0;
      fill_q <= 1'b0;
      res_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        fill_q <= cmd_fill;
        cnt_q  <= one_shot ? CNT_W'(1) : cmd_cnt;
      end else if (state == RUN) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      // sr_q already holds the last falling-edge result here
      if (state != DONE && state_nx == DONE) begin
        res_q <= sr_q;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nx = acc_run ? RUN : DONE;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Reset overrides every control output so the register is
  // cleared and idle from the very cycle rst is seen.
  always_comb begin
    cmd_ready = 1'b0;
    sr_s1     = 1'b0;
    sr_s0     = 1'b0;
    sr_rst    = rst;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: cmd_ready = 1'b1;
        RUN: begin
          busy = 1'b1;
          case (op_q)
            OP_LD: begin
              sr_s1 = 1'b1;
              sr_s0 = 1'b1;
            end
            OP_CLR:         sr_rst = 1'b1;
            OP_SHR, OP_ROR: sr_s0  = 1'b1;
            OP_SHL, OP_ROL: sr_s1  = 1'b1;
            default: ;
          endcase
        end
        DONE: begin
          busy = 1'b1;
          done = 1'b1;
          err  = (op_q == OP_BAD);
        end
        default: ;
      endcase
    end
  end

  assign sr_datain = (state != IDLE) ? data_q : '0;
  assign sr_msbin  = (op_q == OP_ROR) ? sr_q[0] : fill_q;
  assign sr_lsbin  = (op_q == OP_ROL) ? sr_q[WIDTH-1] : fill_q;
  assign result    = res_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: drives shift_seq_ctrl against a falling-edge
// universal shift register and an arithmetic reference model.

module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [2:0] cmd_cnt = '0;
  logic [3:0] cmd_data = '0;
  logic       cmd_fill = 1'b0;
  logic       sr_s1, sr_s0;
  logic [3:0] sr_datain;
  logic       sr_msbin, sr_lsbin, sr_rst;
  logic [3:0] sr_q;
  logic       busy, done, err;
  logic [3:0] result;

  int checks = 0;
  int errors = 0;
  int mdl = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt),
    .cmd_data(cmd_data), .cmd_fill(cmd_fill),
    .sr_s1(sr_s1), .sr_s0(sr_s0),
    .sr_datain(sr_datain),
    .sr_msbin(sr_msbin), .sr_lsbin(sr_lsbin),
    .sr_rst(sr_rst), .sr_q(sr_q),
    .busy(busy), .done(done), .err(err),
    .result(result)
  );

  // the controlled universal shift register
  always @(negedge clk) begin
    if (sr_rst) sr_q <= 4'b0000;
    else begin
      case ({sr_s1, sr_s0})
        2'b01:   sr_q <= {sr_msbin, sr_q[3:1]};
        2'b10:   sr_q <= {sr_q[2:0], sr_lsbin};
        2'b11:   sr_q <= sr_datain;
        default: sr_q <= sr_q;
      endcase
    end
  end

  function automatic int ref_val(int op, int cnt,
                                 int d, int f, int v);
    int r;
    r = v;
    case (op)
      1: r = d;
      6: r = 0;
      2: for (int k = 0; k < cnt; k++) r = r / 2 + f * 8;
      3: for (int k = 0; k < cnt; k++) r = (r * 2) % 16 + f;
      4: for (int k = 0; k < cnt; k++) r = r / 2 + (r % 2) * 8;
      5: for (int k = 0; k < cnt; k++) r = (r * 2) % 16 + r / 8;
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(int op, int cnt);
    if (op == 1 || op == 6) return 2;
    if (op >= 2 && op <= 5 && cnt != 0) return cnt + 1;
    return 1;
  endfunction

  // drive one command and observe it until its done pulse
  task automatic do_cmd(
    input logic [2:0] op, input logic [2:0] cnt,
    input logic [3:0] d, input logic f,
    output int lat, output int m01, output int m10,
    output int m11, output int nrst,
    output logic [3:0] res, output logic er,
    output int pbad);
    int w;
    lat = -1; m01 = 0; m10 = 0; m11 = 0; nrst = 0;
    res = 'x; er = 'x; pbad = 0;
    cmd_op = op; cmd_cnt = cnt; cmd_data = d;
    cmd_fill = f; cmd_valid = 1'b1;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (cmd_ready === 1'b1) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
        case ({sr_s1, sr_s0})
          2'b01: m01++;
          2'b10: m10++;
          2'b11: m11++;
          default: ;
        endcase
        if (sr_rst) nrst++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) pbad++;
        if (done === 1'b1) begin
          lat = i; res = result; er = err;
          break;
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      if (done !== 1'b0) pbad++;
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (sr_rst !== 1'b1 || cmd_ready !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold rst/rdy/busy/done=%b%b%b%b want 1000",
                 sr_rst, cmd_ready, busy, done);
      end
    end
    checks++;
    if (sr_q !== 4'b0000) begin
      errors++;
      $display("FAIL reset_reg got %b want 0000", sr_q);
    end
    rst = 1'b0; #1;
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 ||
        result !== 4'b0000 || {sr_s1, sr_s0} !== 2'b00 ||
        sr_rst !== 1'b0) begin
      errors++;
      $display("FAIL reset_release rdy=%b done=%b res=%b mode=%b%b",
               cmd_ready, done, result, sr_s1, sr_s0);
    end
    mdl = 0;
  endtask

  task automatic test_load;
    int lat, a, b, c, n, pb;
    logic [3:0] res;
    logic er;
    do_cmd(3'd1, 3'd5, 4'b1011, 1'b0,
           lat, a, b, c, n, res, er, pb);
    checks++;
    if (lat !== 2 || c !== 1 || a !== 0 || b !== 0) begin
      errors++;
      $display("FAIL load_timing lat=%0d m11=%0d m01=%0d m10=%0d want 2 1 0 0",
               lat, c, a, b);
    end
    checks++;
    if (res !== 4'b1011 || er !== 1'b0 || sr_q !== 4'b1011) begin
      errors++;
      $display("FAIL load_result res=%b err=%b q=%b want 1011 0 1011",
               res, er, sr_q);
    end
    checks++;
    if (pb !== 0) begin
      errors++;
      $display("FAIL load_proto violations=%0d want 0", pb);
    end
    mdl = 11;
  endtask

  task automatic test_shift;
    int lat, a, b, c, n, pb;
    logic [3:0] res;
    logic er;
    do_cmd(3'd2, 3'd2, 4'b0000, 1'b1,
           lat, a, b, c, n, res, er, pb);
    checks++;
    if (lat !== 3 || a !== 2 || b !== 0 || c !== 0) begin
      errors++;
      $display("FAIL shr_timing lat=%0d m01=%0d m10=%0d m11=%0d want 3 2 0 0",
               lat, a, b, c);
    end
    checks++;
    if (res !== 4'b1110 || er !== 1'b0 || pb !== 0) begin
      errors++;
      $display("FAIL shr_result res=%b err=%b pbad=%0d want 1110 0 0",
               res, er, pb);
    end
    mdl = 14;
  endtask

  task automatic test_rotate;
    int lat, a, b, c, n, pb;
    logic [3:0] res;
    logic er;
    do_cmd(3'd1, 3'd0, 4'b1011, 1'b0,
           lat, a, b, c, n, res, er, pb);
    do_cmd(3'd5, 3'd3, 4'b0000, 1'b0,
           lat, a, b, c, n, res, er, pb);
    checks++;
    if (lat !== 4 || b !== 3 || a !== 0 || res !== 4'b1101) begin
      errors++;
      $display("FAIL rol3 lat=%0d m10=%0d m01=%0d res=%b want 4 3 0 1101",
               lat, b, a, res);
    end
    do_cmd(3'd4, 3'd1, 4'b0000, 1'b0,
           lat, a, b, c, n, res, er, pb);
    checks++;
    if (lat !== 2 || a !== 1 || b !== 0 || res !== 4'b1110) begin
      errors++;
      $display("FAIL ror1 lat=%0d m01=%0d m10=%0d res=%b want 2 1 0 1110",
               lat, a, b, res);
    end
    mdl = 14;
  endtask

  task automatic test_zero_illegal;
    int lat, a, b, c, n, pb;
    logic [3:0] res;
    logic er;
    do_cmd(3'd3, 3'd0, 4'b0101, 1'b1,
           lat, a, b, c, n, res, er, pb);
    checks++;
    if (lat !== 1 || a + b + c + n !== 0 || er !== 1'b0 ||
        res !== 4'b1110 || sr_q !== 4'b1110) begin
      errors++;
      $display("FAIL shl0 lat=%0d act=%0d err=%b res=%b q=%b want 1 0 0 1110 1110",
               lat, a + b + c + n, er, res, sr_q);
    end
    do_cmd(3'd7, 3'd4, 4'b0101, 1'b1,
           lat, a, b, c, n, res, er, pb);
    checks++;
    if (lat !== 1 || a + b + c + n !== 0 || er !== 1'b1 ||
        sr_q !== 4'b1110) begin
      errors++;
      $display("FAIL illegal lat=%0d act=%0d err=%b q=%b want 1 0 1 1110",
               lat, a + b + c + n, er, sr_q);
    end
    do_cmd(3'd0, 3'd4, 4'b0101, 1'b1,
           lat, a, b, c, n, res, er, pb);
    checks++;
    if (lat !== 1 || er !== 1'b0 || sr_q !== 4'b1110) begin
      errors++;
      $display("FAIL nop lat=%0d err=%b q=%b want 1 0 1110",
               lat, er, sr_q);
    end
    do_cmd(3'd6, 3'd0, 4'b0000, 1'b0,
           lat, a, b, c, n, res, er, pb);
    checks++;
    if (lat !== 2 || n !== 1 || a + b + c !== 0 ||
        res !== 4'b0000 || er !== 1'b0) begin
      errors++;
      $display("FAIL clear lat=%0d rst=%0d mode=%0d res=%b err=%b want 2 1 0 0000 0",
               lat, n, a + b + c, res, er);
    end
    mdl = 0;
  endtask

  task automatic test_reset_midrun;
    int lat, a, b, c, n, pb, w, nd;
    logic [3:0] res;
    logic er;
    do_cmd(3'd1, 3'd0, 4'b1011, 1'b0,
           lat, a, b, c, n, res, er, pb);
    cmd_op = 3'd4; cmd_cnt = 3'd7; cmd_valid = 1'b1;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if ({sr_s1, sr_s0} !== 2'b01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pre mode=%b%b busy=%b want 01 1",
               sr_s1, sr_s0, busy);
    end
    rst = 1'b1; #1;
    checks++;
    if (sr_rst !== 1'b1 || {sr_s1, sr_s0} !== 2'b00 ||
        cmd_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_rst rst=%b mode=%b%b rdy=%b busy=%b done=%b",
               sr_rst, sr_s1, sr_s0, cmd_ready, busy, done);
    end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 ||
        result !== 4'b0000 || sr_q !== 4'b0000 ||
        {sr_s1, sr_s0} !== 2'b00) begin
      errors++;
      $display("FAIL midrun_after rdy=%b busy=%b res=%b q=%b want 1 0 0000 0000",
               cmd_ready, busy, result, sr_q);
    end
    nd = 0;
    repeat (10) begin
      if (done === 1'b1) nd++;
      @(posedge clk); #1;
    end
    checks++;
    if (nd !== 0 || sr_q !== 4'b0000) begin
      errors++;
      $display("FAIL midrun_nodone pulses=%0d q=%b want 0 0000", nd, sr_q);
    end
    mdl = 0;
  endtask

  task automatic test_back_to_back;
    int lat, a, b, c, n, pb, w, di, ri;
    logic [3:0] res, hold;
    logic er, m1;
    cmd_op = 3'd1; cmd_cnt = 3'd0; cmd_data = 4'b0110;
    cmd_fill = 1'b0; cmd_valid = 1'b1;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    cmd_op = 3'd3; cmd_cnt = 3'd2; cmd_data = 4'b0000;
    cmd_fill = 1'b1;
    m1 = ({sr_s1, sr_s0} === 2'b11);
    di = -1; ri = -1; hold = 'x;
    for (int i = 1; i <= 10; i++) begin
      if (done === 1'b1 && di < 0) di = i;
      if (cmd_ready === 1'b1) begin
        ri = i; hold = result;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!m1 || di !== 2 || ri !== 3 || hold !== 4'b0110) begin
      errors++;
      $display("FAIL b2b_first ld=%b done@%0d rdy@%0d res=%b want 1 2 3 0110",
               m1, di, ri, hold);
    end
    do_cmd(3'd3, 3'd2, 4'b0000, 1'b1,
           lat, a, b, c, n, res, er, pb);
    checks++;
    if (lat !== 3 || b !== 2 || res !== 4'b1011 || pb !== 0) begin
      errors++;
      $display("FAIL b2b_second lat=%0d m10=%0d res=%b pbad=%0d want 3 2 1011 0",
               lat, b, res, pb);
    end
    mdl = 11;
  endtask

  task automatic test_random;
    int lat, a, b, c, n, pb, op, cnt, d, f, ev, el;
    int em01, em10, em11, en;
    logic [3:0] res;
    logic er;
    for (int t = 0; t < 60; t++) begin
      op  = $urandom_range(7, 0);
      cnt = $urandom_range(7, 0);
      d   = $urandom_range(15, 0);
      f   = $urandom_range(1, 0);
      ev  = ref_val(op, cnt, d, f, mdl);
      el  = ref_lat(op, cnt);
      em01 = ((op == 2 || op == 4) ? cnt : 0);
      em10 = ((op == 3 || op == 5) ? cnt : 0);
      em11 = (op == 1) ? 1 : 0;
      en   = (op == 6) ? 1 : 0;
      do_cmd(3'(op), 3'(cnt), 4'(d), f[0],
             lat, a, b, c, n, res, er, pb);
      checks++;
      if (lat !== el || a !== em01 || b !== em10 ||
          c !== em11 || n !== en || pb !== 0) begin
        errors++;
        $display("FAIL rand_timing op=%0d cnt=%0d lat=%0d/%0d m=%0d,%0d,%0d/%0d,%0d,%0d clr=%0d/%0d pbad=%0d",
                 op, cnt, lat, el, a, b, c, em01, em10, em11,
                 n, en, pb);
      end
      checks++;
      if (res !== 4'(ev) || sr_q !== 4'(ev) ||
          er !== (op == 7)) begin
        errors++;
        $display("FAIL rand_value op=%0d cnt=%0d d=%0d f=%0d res=%b q=%b err=%b want %b %b",
                 op, cnt, d, f, res, sr_q, er, 4'(ev), (op == 7));
      end
      mdl = ev;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift();
    test_rotate();
    test_zero_illegal();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
